scr_ndim_core: RTL and testbench
================================

Name: scr_ndim_core

Overview:
- Parallel, parametrised successor of the 1-bit additive scrambler core.
- Scrambles DATA_WIDTH bits per beat using an LFSR with a generic feedback polynomial.
- Optionally reloads the seed automatically every FRAME_LEN beats.
- Sits in the TX/RX datapath between framer and line coder; the same core is instantiated as a descrambler.

Parameters:
- DATA_WIDTH, 8, bits per beat; data_in[0] is first in time.
- SCR_WIDTH, 7, LFSR length; legal range 2..32.
- TAPS, 7'b1100000, feedback mask of width SCR_WIDTH; bit k set means s[k] is XORed into the feedback. The default is x^7+x^6+1.
- INIT_DEFAULT, 7'h7F, seed-register value after reset.
- FRAME_LEN, 0, beats per frame before automatic reseed; 0 disables reseed. Counter width is clog2(FRAME_LEN+1), minimum 1.

Ports:
- clk  in  1  clock; all logic is on posedge.
- kill  in  1  reset, asynchronous, active-high.
- scr_en  in  1  1 = XOR the sequence onto the data; 0 = pass data through (LFSR still advances).
- data_in  in  DATA_WIDTH  input beat.
- data_in_en  in  1  beat valid.
- init_val  in  SCR_WIDTH  seed value.
- init_val_en  in  1  load seed; applies to the current beat.
- data_out  out  DATA_WIDTH  output beat.
- data_out_en  out  1  output valid.
- frame_start  out  1  high with the first output beat of each frame.

Behaviour:
- Reset (kill=1, asynchronous): scr_reg=0, seed_reg=INIT_DEFAULT, frame_cnt=0, data_out=0, data_out_en=0, frame_start=0. The first beat after reset uses scr_reg=0 unless init_val_en is asserted.
- Single LFSR step on state s:
  - fb = XOR over k of (s[k] & TAPS[k])
  - s_next = {s[SCR_WIDTH-2:0], fb}
  - Data bit i uses the fb of step i, for i = 0..DATA_WIDTH-1, chained combinationally within one cycle.
- Seed for a beat: seed = init_val_en ? init_val : scr_reg.
- Per-bit output: out[i] = data_in[i] ^ (scr_en ? fb_i : 0).
- Register priority (highest first):
  - kill
  - init_val_en: seed_reg <= init_val; frame_cnt <= (data_in_en ? 1 : 0); scr_reg <= data_in_en ? advanced(init_val) : init_val
  - data_in_en with FRAME_LEN>0 and frame_cnt==FRAME_LEN-1: scr_reg <= seed_reg; frame_cnt <= 0
  - data_in_en otherwise: scr_reg <= advanced(scr_reg), i.e. DATA_WIDTH steps; frame_cnt++ when FRAME_LEN>0
  - idle: hold all state
- Output stage:
  - Latency is exactly 1 cycle. data_out_en <= data_in_en. data_out <= data_in_en ? out : 0.
  - frame_start <= data_in_en & (frame_cnt==0 or init_val_en).
- With FRAME_LEN=0, frame_start pulses only on beats that carry init_val_en.
- Back-to-back beats: full throughput, one beat per cycle, no bubbles.
- init_val_en without data_in_en: seed is loaded; no output; frame_cnt=0.
- An all-zero seed is legal; with scr_en=1 the output then equals the input.
- kill mid-frame: frame restarts; the next frame_start requires a beat.

Optional Feature:
- Macro: SCR_SELF_SYNC_EN.
- Defined:
  - Adds input desc_mode (1 bit) after scr_en.
  - The LFSR becomes multiplicative (self-synchronising). The bit shifted in per step is out[i] when desc_mode=0 (scramble) and data_in[i] when desc_mode=1 (descramble).
  - The automatic frame reseed is suppressed in this mode; frame_cnt and frame_start still run.
- Undefined: no desc_mode port; additive mode only, as described above.

Test Plan:
- Default parameters; kill pulse; init_val=7'h7F with init_val_en=1; two beats of data_in=8'h00, scr_en=1 → data_out=8'h40 then 8'h30. data_out_en high exactly 1 cycle after each beat; frame_start high on the first beat only.
- Same sequence with scr_en=0 and data_in=8'hA5 → data_out=8'hA5. Afterwards re-enable scr_en without reseed → the output continues the sequence from state 7'h0C (3rd beat), proving the LFSR advanced.
- Chain two instances (scrambler → descrambler) with identical seeds; 1000 random beats → recovered data equals the original, with 2-cycle total latency.
- FRAME_LEN=4; seed 7'h7F; 9 continuous zero beats → beats 1, 5 and 9 output 8'h40; frame_start high on exactly those beats.
- Assert kill asynchronously (between clock edges) mid-stream → all outputs 0 immediately, without waiting for a clock edge. The first beat afterwards, with no init_val_en, outputs data unchanged (scr_reg=0).
- SCR_SELF_SYNC_EN defined: scrambler with desc_mode=0 and seed 7'h7F feeds a descrambler with desc_mode=1 and seed 7'h00 → descrambler output matches the original data from beat 2 onward (within SCR_WIDTH=7 bits).

Source files
------------

// File: rtl/scr_ndim_core_if.sv
// Beat-level bus of scr_ndim_core: input beat, seed load and the registered output beat.
// desc_mode is present only when SCR_SELF_SYNC_EN is defined.
interface scr_ndim_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SCR_WIDTH  = 7
);
  logic                  scr_en;
`ifdef SCR_SELF_SYNC_EN
  logic                  desc_mode;
`endif
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_en;
  logic [SCR_WIDTH-1:0]  init_val;
  logic                  init_val_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_en;
  logic                  frame_start;

  modport master (
    output scr_en,
`ifdef SCR_SELF_SYNC_EN
    output desc_mode,
`endif
    output data_in, data_in_en, init_val, init_val_en,
    input  data_out, data_out_en, frame_start
  );

  modport slave (
    input  scr_en,
`ifdef SCR_SELF_SYNC_EN
    input  desc_mode,
`endif
    input  data_in, data_in_en, init_val, init_val_en,
    output data_out, data_out_en, frame_start
  );
endinterface

// File: rtl/scr_ndim_core.sv
// Parallel LFSR scrambler/descrambler, DATA_WIDTH bits per beat, optional frame reseed.
// Define SCR_SELF_SYNC_EN for the multiplicative (self-synchronising) variant with desc_mode.
module scr_ndim_core #(
  parameter int                   DATA_WIDTH   = 8,
  parameter int                   SCR_WIDTH    = 7,
  parameter logic [SCR_WIDTH-1:0] TAPS         = 7'b1100000,
  parameter logic [SCR_WIDTH-1:0] INIT_DEFAULT = 7'h7F,
  parameter int                   FRAME_LEN    = 0
) (
  input logic            clk,
  input logic            kill,
  scr_ndim_core_if.slave bus
);

  localparam bit             FRAMED   = (FRAME_LEN > 0);
  localparam int             CNT_W    = FRAMED ? $clog2(FRAME_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMED ? FRAME_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SCR_WIDTH-1:0]  scr_reg;
  logic [SCR_WIDTH-1:0]  seed_reg;
  logic [SCR_WIDTH-1:0]  lfsr;
  logic [SCR_WIDTH-1:0]  advanced;
  logic [CNT_W-1:0]      frame_cnt;
  logic [DATA_WIDTH-1:0] out;
  logic                  fb;
  logic                  shift_in;
  logic                  frame_wrap;
  logic                  reseed;

  // Unrolled LFSR: bit i of the beat sees the feedback of step i, all within one cycle
  always_comb begin
    lfsr     = bus.init_val_en ? bus.init_val : scr_reg;
    out      = '0;
    fb       = 1'b0;
    shift_in = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb     = ^(lfsr & TAPS);
      out[i] = bus.data_in[i] ^ (bus.scr_en & fb);
`ifdef SCR_SELF_SYNC_EN
      shift_in = bus.desc_mode ? bus.data_in[i] : out[i];
`else
      shift_in = fb;
`endif
      lfsr = {lfsr[SCR_WIDTH-2:0], shift_in};
    end
    advanced = lfsr;
  end

  assign frame_wrap = FRAMED && (frame_cnt == CNT_LAST);
`ifdef SCR_SELF_SYNC_EN
  assign reseed = 1'b0;
`else
  assign reseed = frame_wrap;
`endif

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      scr_reg   <= '0;
      seed_reg  <= INIT_DEFAULT;
      frame_cnt <= '0;
    end else if (bus.init_val_en) begin
      seed_reg  <= bus.init_val;
      frame_cnt <= bus.data_in_en ? CNT_ONE : '0;
      scr_reg   <= bus.data_in_en ? advanced : bus.init_val;
    end else if (bus.data_in_en) begin
      scr_reg <= reseed ? seed_reg : advanced;
      if (frame_wrap)
        frame_cnt <= '0;
      else if (FRAMED)
        frame_cnt <= frame_cnt + CNT_ONE;
    end
  end

  // Single register stage on the output side gives the fixed one-cycle latency
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      bus.data_out    <= '0;
      bus.data_out_en <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.data_out_en <= bus.data_in_en;
      bus.data_out    <= bus.data_in_en ? out : '0;
      bus.frame_start <= bus.data_in_en &
                         (bus.init_val_en | (FRAMED && (frame_cnt == '0)));
    end
  end

endmodule

// File: tb/tb_scr_ndim_core.sv
// Randomised self-checking bench for scr_ndim_core against a bit-serial reference model.
// Builds with or without SCR_SELF_SYNC_EN; fixed-value checks apply to the additive mode.
module tb_scr_ndim_core;

  localparam int             DW   = 8;
  localparam int             SW   = 7;
  localparam logic [SW-1:0]  TAPS = 7'b1100000;
`ifdef SCR_SELF_SYNC_EN
  localparam bit SELF_SYNC = 1'b1;
`else
  localparam bit SELF_SYNC = 1'b0;
`endif

  typedef struct packed {
    logic [SW-1:0] state;
    logic [SW-1:0] seed;
    logic [31:0]   cnt;
  } mdl_t;

  logic  clk  = 1'b0;
  logic  kill = 1'b1;
  int    checks = 0;
  int    errors = 0;
  mdl_t  mdl_a;
  mdl_t  mdl_f;
  logic  prev_en;
  logic [DW-1:0] prev_d;

  scr_ndim_core_if #(.DATA_WIDTH(DW), .SCR_WIDTH(SW)) bus_a ();
  scr_ndim_core_if #(.DATA_WIDTH(DW), .SCR_WIDTH(SW)) bus_b ();
  scr_ndim_core_if #(.DATA_WIDTH(DW), .SCR_WIDTH(SW)) bus_f ();

  scr_ndim_core #(.DATA_WIDTH(DW), .SCR_WIDTH(SW), .TAPS(TAPS),
                  .INIT_DEFAULT(7'h7F), .FRAME_LEN(0))
    u_a (.clk(clk), .kill(kill), .bus(bus_a));

  scr_ndim_core #(.DATA_WIDTH(DW), .SCR_WIDTH(SW), .TAPS(TAPS),
                  .INIT_DEFAULT(7'h7F), .FRAME_LEN(0))
    u_b (.clk(clk), .kill(kill), .bus(bus_b));

  scr_ndim_core #(.DATA_WIDTH(DW), .SCR_WIDTH(SW), .TAPS(TAPS),
                  .INIT_DEFAULT(7'h7F), .FRAME_LEN(4))
    u_f (.clk(clk), .kill(kill), .bus(bus_f));

  assign bus_b.data_in    = bus_a.data_out;
  assign bus_b.data_in_en = bus_a.data_out_en;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the keystream one bit at a time straight from the feedback rule
  function automatic void modelBeat(input int flen, input logic en, input logic scr,
                                    input logic desc, input logic [DW-1:0] din,
                                    input logic ld, input logic [SW-1:0] iv, inout mdl_t m,
                                    output logic [DW-1:0] dout, output logic den,
                                    output logic fs);
    logic [SW-1:0] s;
    logic [DW-1:0] o;
    int            fbit;
    logic          sin;
    s = ld ? iv : m.state;
    o = '0;
    for (int i = 0; i < DW; i++) begin
      fbit = $countones(s & TAPS) % 2;
      o[i] = din[i] ^ (scr & fbit[0]);
      if (SELF_SYNC) sin = desc ? din[i] : o[i];
      else           sin = fbit[0];
      s = {s[SW-2:0], sin};
    end
    dout = en ? o : '0;
    den  = en;
    fs   = en & (ld | ((flen > 0) && (m.cnt == 32'd0)));
    if (ld) begin
      m.seed  = iv;
      m.cnt   = en ? 32'd1 : 32'd0;
      m.state = en ? s : iv;
    end else if (en) begin
      if ((flen > 0) && (m.cnt == 32'(flen - 1))) begin
        m.cnt   = 32'd0;
        m.state = SELF_SYNC ? s : m.seed;
      end else begin
        m.state = s;
        if (flen > 0) m.cnt = m.cnt + 32'd1;
      end
    end
  endfunction

  task automatic modelReset();
    mdl_a.state = '0; mdl_a.seed = 7'h7F; mdl_a.cnt = 32'd0;
    mdl_f.state = '0; mdl_f.seed = 7'h7F; mdl_f.cnt = 32'd0;
  endtask

  task automatic applyStimulus(input int which, input logic en, input logic scr,
                               input logic desc, input logic [DW-1:0] din,
                               input logic ld, input logic [SW-1:0] iv);
    if (which == 0) begin
      bus_a.data_in_en = en; bus_a.scr_en = scr; bus_a.data_in = din;
      bus_a.init_val_en = ld; bus_a.init_val = iv;
`ifdef SCR_SELF_SYNC_EN
      bus_a.desc_mode = desc;
`endif
    end else begin
      bus_f.data_in_en = en; bus_f.scr_en = scr; bus_f.data_in = din;
      bus_f.init_val_en = ld; bus_f.init_val = iv;
`ifdef SCR_SELF_SYNC_EN
      bus_f.desc_mode = desc;
`endif
    end
  endtask

  task automatic beat(input int which, input logic en, input logic scr, input logic desc,
                      input logic [DW-1:0] din, input logic ld, input logic [SW-1:0] iv);
    logic [DW-1:0] e_d;
    logic          e_en, e_fs;
    @(negedge clk);
    applyStimulus(which, en, scr, desc, din, ld, iv);
    if (which == 0) modelBeat(0, en, scr, desc, din, ld, iv, mdl_a, e_d, e_en, e_fs);
    else            modelBeat(4, en, scr, desc, din, ld, iv, mdl_f, e_d, e_en, e_fs);
    @(posedge clk);
    #1;
    if (which == 0) begin
      checkOutput("a_data_out", 32'(bus_a.data_out), 32'(e_d));
      checkOutput("a_data_out_en", 32'(bus_a.data_out_en), 32'(e_en));
      checkOutput("a_frame_start", 32'(bus_a.frame_start), 32'(e_fs));
    end else begin
      checkOutput("f_data_out", 32'(bus_f.data_out), 32'(e_d));
      checkOutput("f_data_out_en", 32'(bus_f.data_out_en), 32'(e_en));
      checkOutput("f_frame_start", 32'(bus_f.frame_start), 32'(e_fs));
    end
  endtask

  task automatic idleAll();
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doKill();
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    modelReset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] r;
    logic [SW-1:0] seed;
    logic          en;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    bus_b.scr_en = 1'b1; bus_b.init_val_en = 1'b0; bus_b.init_val = '0;
`ifdef SCR_SELF_SYNC_EN
    bus_b.desc_mode = 1'b1;
`endif
    modelReset();
    #2;
    checkOutput("rst_data_out", 32'(bus_a.data_out), 32'd0);
    checkOutput("rst_data_out_en", 32'(bus_a.data_out_en), 32'd0);
    checkOutput("rst_frame_start", 32'(bus_f.frame_start), 32'd0);
    @(negedge clk);
    kill = 1'b0;

    $display("[TB] seeded zero beats");
    beat(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 7'h7F);
`ifndef SCR_SELF_SYNC_EN
    checkOutput("spec_beat1", 32'(bus_a.data_out), 32'h40);
`endif
    checkOutput("spec_fs1", 32'(bus_a.frame_start), 32'd1);
    beat(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
`ifndef SCR_SELF_SYNC_EN
    checkOutput("spec_beat2", 32'(bus_a.data_out), 32'h30);
`endif
    checkOutput("spec_fs2", 32'(bus_a.frame_start), 32'd0);
    beat(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
    checkOutput("spec_en_drop", 32'(bus_a.data_out_en), 32'd0);

    $display("[TB] bypass then resume");
    doKill();
    beat(0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 7'h7F);
    checkOutput("bypass1", 32'(bus_a.data_out), 32'hA5);
    beat(0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 7'h00);
    checkOutput("bypass2", 32'(bus_a.data_out), 32'hA5);
    beat(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
`ifndef SCR_SELF_SYNC_EN
    checkOutput("resume_beat3", 32'(bus_a.data_out), 32'h14);
`endif

    $display("[TB] asynchronous kill");
    beat(0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 7'h00);
    #2;
    kill = 1'b1;
    #1;
    checkOutput("akill_data_out", 32'(bus_a.data_out), 32'd0);
    checkOutput("akill_data_out_en", 32'(bus_a.data_out_en), 32'd0);
    checkOutput("akill_frame_start", 32'(bus_a.frame_start), 32'd0);
    @(negedge clk);
    kill = 1'b0;
    modelReset();
    r = 8'($urandom);
    beat(0, 1'b1, 1'b1, 1'b0, r, 1'b0, 7'h00);
`ifndef SCR_SELF_SYNC_EN
    checkOutput("akill_zero_state", 32'(bus_a.data_out), 32'(r));
`endif

    $display("[TB] frame reseed");
    idleAll();
    doKill();
    for (int k = 1; k <= 9; k++) begin
      beat(1, 1'b1, 1'b1, 1'b0, 8'h00, (k == 1), 7'h7F);
      checkOutput("frame_fs", 32'(bus_f.frame_start), 32'((k == 1) || (k == 5) || (k == 9)));
`ifndef SCR_SELF_SYNC_EN
      if ((k == 1) || (k == 5) || (k == 9))
        checkOutput("frame_reseed_data", 32'(bus_f.data_out), 32'h40);
`endif
    end

    $display("[TB] random framed traffic");
    for (int n = 0; n < 300; n++)
      beat(1, ($urandom_range(0, 99) < 75), 1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 99) < 10), 7'($urandom));

    $display("[TB] scrambler to descrambler chain");
    idleAll();
    applyStimulus(0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    seed = 7'($urandom);
    bus_b.init_val = seed;
    bus_b.init_val_en = 1'b1;
    beat(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, seed);
    bus_b.init_val_en = 1'b0;
    prev_en = 1'b0;
    prev_d  = '0;
    for (int n = 0; n <= 1000; n++) begin
      en = (n < 1000) && ($urandom_range(0, 99) < 90);
      r  = 8'($urandom);
      beat(0, en, 1'b1, 1'b0, r, 1'b0, 7'h00);
      checkOutput("chain_en", 32'(bus_b.data_out_en), 32'(prev_en));
      if (prev_en)
        checkOutput("chain_data", 32'(bus_b.data_out), 32'(prev_d));
      prev_en = en;
      prev_d  = r;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
